// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: port A (single-cycle datapath, jal/jalr link) over a
// buffered port B (multi-cycle producers) with a busy scoreboard. Define WB_BYPASS_EN to let
// port-B requests skip an empty FIFO.
module regfile_write_arbiter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          CLK,
  input  logic          Reset_n,
  input  logic          a_wr,
  input  logic [4:0]    a_reg,
  input  logic [31:0]   a_data,
  input  logic          a_link,
  input  logic [31:0]   a_pc,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [4:0]    b_reg,
  input  logic [31:0]   b_data,
  input  logic          iss_valid,
  input  logic [4:0]    iss_reg,
  output logic          RegWr,
  output logic [4:0]    WriteReg,
  output logic [31:0]   WriteData,
  output logic [31:0]   busy,
  output logic [AW:0]   fifo_level
);

  localparam int unsigned RW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned NREG = 32;
  localparam logic [RW-1:0] LINK_REG = RW'(31);

  logic [RW-1:0]   fifo_reg_q  [DEPTH];
  logic [DW-1:0]   fifo_data_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     level_q, level_d;
  logic            regwr_q, regwr_d;
  logic [RW-1:0]   wreg_q, wreg_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [NREG-1:0] busy_q, busy_d;

  logic            a_take_c, a_sel_c, pop_c, push_c, bypass_c;
  logic [RW-1:0]   head_reg_c;
  logic [DW-1:0]   head_data_c;

  assign b_ready     = (level_q != (AW+1)'(DEPTH));
  assign head_reg_c  = fifo_reg_q[rd_ptr_q];
  assign head_data_c = fifo_data_q[rd_ptr_q];

  // Source selection, FIFO bookkeeping and scoreboard update
  always_comb begin
    a_take_c = a_wr && (a_reg != '0);
    a_sel_c  = a_take_c || a_link;
    pop_c    = !a_sel_c && (level_q != '0);
`ifdef WB_BYPASS_EN
    bypass_c = !a_sel_c && (level_q == '0) && b_valid;
`else
    bypass_c = 1'b0;
`endif
    push_c   = b_valid && b_ready && !bypass_c;

    regwr_d = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;

    if (a_take_c) begin
      regwr_d = 1'b1;
      wreg_d  = a_reg;
      wdata_d = a_data;
    end else if (a_link) begin
      regwr_d = 1'b1;
      wreg_d  = LINK_REG;
      wdata_d = a_pc + DW'(4);
    end else if (pop_c) begin
      regwr_d = (head_reg_c != '0);
      wreg_d  = head_reg_c;
      wdata_d = head_data_c;
      busy_d[head_reg_c] = 1'b0;
    end else if (bypass_c) begin
      regwr_d = (b_reg != '0);
      wreg_d  = b_reg;
      wdata_d = b_data;
      busy_d[b_reg] = 1'b0;
    end

    // A fresh issue outranks a completing write to the same register
    if (iss_valid && (iss_reg != '0)) begin
      busy_d[iss_reg] = 1'b1;
    end
    busy_d[0] = 1'b0;

    wr_ptr_d = wr_ptr_q + AW'(push_c);
    rd_ptr_d = rd_ptr_q + AW'(pop_c);
    level_d  = level_q;
    if (push_c && !pop_c) begin
      level_d = level_q + (AW+1)'(1);
    end else if (!push_c && pop_c) begin
      level_d = level_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      regwr_q  <= 1'b0;
      wreg_q   <= '0;
      wdata_q  <= '0;
      busy_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      regwr_q  <= regwr_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
    end
  end

  // Payload storage needs no reset; only the pointers define validity
  always_ff @(posedge CLK) begin
    if (push_c) begin
      fifo_reg_q[wr_ptr_q]  <= b_reg;
      fifo_data_q[wr_ptr_q] <= b_data;
    end
  end

  assign RegWr      = regwr_q;
  assign WriteReg   = wreg_q;
  assign WriteData  = wdata_q;
  assign busy       = busy_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus randomized traffic against a
// queue-based reference model. Honours WB_BYPASS_EN when defined.
module tb_regfile_write_arbiter;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  logic        CLK;
  logic        Reset_n;
  logic        a_wr;
  logic [4:0]  a_reg;
  logic [31:0] a_data;
  logic        a_link;
  logic [31:0] a_pc;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_reg;
  logic [31:0] b_data;
  logic        iss_valid;
  logic [4:0]  iss_reg;
  logic        RegWr;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [31:0] busy;
  logic [AW:0] fifo_level;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_write_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK(CLK), .Reset_n(Reset_n),
    .a_wr(a_wr), .a_reg(a_reg), .a_data(a_data), .a_link(a_link), .a_pc(a_pc),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .iss_valid(iss_valid), .iss_reg(iss_reg),
    .RegWr(RegWr), .WriteReg(WriteReg), .WriteData(WriteData),
    .busy(busy), .fifo_level(fifo_level)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    a_wr = 0; a_reg = 0; a_data = 0; a_link = 0; a_pc = 0;
    b_valid = 0; b_reg = 0; b_data = 0; iss_valid = 0; iss_reg = 0;
  endtask

  task automatic test_reset();
    Reset_n = 0;
    idle_inputs();
    tick(); tick();
    n_checks++; if (RegWr !== 1'b0) begin n_fail++; $display("FAIL reset_regwr got %0b want 0", RegWr); end
    n_checks++; if (WriteReg !== 5'd0) begin n_fail++; $display("FAIL reset_wreg got %0d want 0", WriteReg); end
    n_checks++; if (WriteData !== 32'd0) begin n_fail++; $display("FAIL reset_wdata got %h want 0", WriteData); end
    n_checks++; if (busy !== 32'd0) begin n_fail++; $display("FAIL reset_busy got %h want 0", busy); end
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    n_checks++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL reset_bready got %0b want 1", b_ready); end
    Reset_n = 1;
  endtask

  task automatic test_reset_mid();
    a_wr = 1; a_reg = 3; a_data = 32'h1;
    iss_valid = 1; iss_reg = 12;
    b_valid = 1;
    for (int i = 0; i < 3; i++) begin
      b_reg = 5'(i + 1); b_data = 32'(i + 32'h50);
      tick();
      iss_valid = 0;
    end
    b_valid = 0;
    n_checks++; if (fifo_level !== 3'd3) begin n_fail++; $display("FAIL mid_pre_level got %0d want 3", fifo_level); end
    n_checks++; if (busy[12] !== 1'b1) begin n_fail++; $display("FAIL mid_pre_busy12 got %0b want 1", busy[12]); end
    Reset_n = 0;
    tick();
    n_checks++; if (RegWr !== 1'b0) begin n_fail++; $display("FAIL mid_rst_regwr got %0b want 0", RegWr); end
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL mid_rst_level got %0d want 0", fifo_level); end
    n_checks++; if (busy !== 32'd0) begin n_fail++; $display("FAIL mid_rst_busy got %h want 0", busy); end
    n_checks++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_bready got %0b want 1", b_ready); end
    Reset_n = 1;
    idle_inputs();
    tick();
    n_checks++; if (RegWr !== 1'b0) begin n_fail++; $display("FAIL mid_post_idle got %0b want 0", RegWr); end
    a_wr = 1; a_reg = 5; a_data = 32'h11;
    tick();
    a_wr = 0;
    n_checks++; if ({RegWr, WriteReg, WriteData} !== {1'b1, 5'd5, 32'h11})
      begin n_fail++; $display("FAIL mid_post_write got %0b/%0d/%h want 1/5/11", RegWr, WriteReg, WriteData); end
    tick();
    n_checks++; if (RegWr !== 1'b0 || fifo_level !== 3'd0)
      begin n_fail++; $display("FAIL mid_post_alone got regwr %0b level %0d want 0/0", RegWr, fifo_level); end
  endtask

  task automatic test_port_a();
    a_wr = 1; a_reg = 8; a_data = 32'hDEADBEEF;
    tick();
    idle_inputs();
    n_checks++; if ({RegWr, WriteReg, WriteData} !== {1'b1, 5'd8, 32'hDEADBEEF})
      begin n_fail++; $display("FAIL porta_write got %0b/%0d/%h want 1/8/deadbeef", RegWr, WriteReg, WriteData); end
    tick();
    n_checks++; if ({RegWr, WriteReg, WriteData} !== {1'b0, 5'd8, 32'hDEADBEEF})
      begin n_fail++; $display("FAIL porta_hold got %0b/%0d/%h want 0/8/deadbeef", RegWr, WriteReg, WriteData); end
    a_wr = 1; a_reg = 0; a_data = 32'h77;
    tick();
    idle_inputs();
    n_checks++; if (RegWr !== 1'b0 || fifo_level !== 3'd0)
      begin n_fail++; $display("FAIL porta_r0 got regwr %0b level %0d want 0/0", RegWr, fifo_level); end
  endtask

  task automatic test_link();
    a_link = 1; a_pc = 32'h00400010;
    tick();
    n_checks++; if ({RegWr, WriteReg, WriteData} !== {1'b1, 5'd31, 32'h00400014})
      begin n_fail++; $display("FAIL link got %0b/%0d/%h want 1/31/00400014", RegWr, WriteReg, WriteData); end
    a_wr = 1; a_reg = 0; a_data = 32'h5; a_pc = 32'hFFFFFFFC;
    tick();
    idle_inputs();
    n_checks++; if ({RegWr, WriteReg, WriteData} !== {1'b1, 5'd31, 32'h0})
      begin n_fail++; $display("FAIL link_wrap got %0b/%0d/%h want 1/31/0", RegWr, WriteReg, WriteData); end
  endtask

  task automatic test_port_b_latency();
    iss_valid = 1; iss_reg = 9;
    tick();
    iss_valid = 0;
    n_checks++; if (busy[9] !== 1'b1) begin n_fail++; $display("FAIL lat_busy_set got %0b want 1", busy[9]); end
    tick(); tick();
    b_valid = 1; b_reg = 9; b_data = 32'h1234;
    tick();
    b_valid = 0;
`ifdef WB_BYPASS_EN
    n_checks++; if ({RegWr, WriteReg, WriteData} !== {1'b1, 5'd9, 32'h1234})
      begin n_fail++; $display("FAIL lat_bypass got %0b/%0d/%h want 1/9/1234", RegWr, WriteReg, WriteData); end
    n_checks++; if (busy[9] !== 1'b0 || fifo_level !== 3'd0)
      begin n_fail++; $display("FAIL lat_bypass_state got busy9 %0b level %0d want 0/0", busy[9], fifo_level); end
`else
    n_checks++; if (RegWr !== 1'b0 || busy[9] !== 1'b1 || fifo_level !== 3'd1)
      begin n_fail++; $display("FAIL lat_queued got regwr %0b busy9 %0b level %0d want 0/1/1", RegWr, busy[9], fifo_level); end
    tick();
    n_checks++; if ({RegWr, WriteReg, WriteData} !== {1'b1, 5'd9, 32'h1234})
      begin n_fail++; $display("FAIL lat_pop got %0b/%0d/%h want 1/9/1234", RegWr, WriteReg, WriteData); end
    n_checks++; if (busy[9] !== 1'b0 || fifo_level !== 3'd0)
      begin n_fail++; $display("FAIL lat_pop_state got busy9 %0b level %0d want 0/0", busy[9], fifo_level); end
`endif
    tick();
  endtask

  task automatic test_fill_drain();
    int accepted;
    int lvl;
    logic acc;
    accepted = 0;
    a_wr = 1; a_reg = 20; a_data = 32'hA5A5;
    b_valid = 1;
    for (int i = 0; i < 6; i++) begin
      b_reg = 5'(accepted + 1); b_data = 32'(32'h100 + accepted + 1);
      if (b_ready) accepted++;
      tick();
    end
    n_checks++; if (accepted !== 4) begin n_fail++; $display("FAIL fill_accepts got %0d want 4", accepted); end
    n_checks++; if (fifo_level !== 3'd4 || b_ready !== 1'b0)
      begin n_fail++; $display("FAIL fill_full got level %0d ready %0b want 4/0", fifo_level, b_ready); end
    n_checks++; if (RegWr !== 1'b1 || WriteReg !== 5'd20)
      begin n_fail++; $display("FAIL fill_porta got %0b/%0d want 1/20", RegWr, WriteReg); end
    a_wr = 0;
    lvl = 4;
    for (int k = 1; k <= 5; k++) begin
      acc = b_valid && b_ready;
      tick();
      if (acc) b_valid = 0;
      lvl = lvl + int'(acc) - 1;
      n_checks++; if ({RegWr, WriteReg, WriteData} !== {1'b1, 5'(k), 32'(32'h100 + k)})
        begin n_fail++; $display("FAIL drain_%0d got %0b/%0d/%h want 1/%0d/%h", k, RegWr, WriteReg, WriteData, k, 32'h100 + k); end
      n_checks++; if (fifo_level !== 3'(lvl))
        begin n_fail++; $display("FAIL drain_level_%0d got %0d want %0d", k, fifo_level, lvl); end
    end
    idle_inputs();
    tick();
    n_checks++; if (RegWr !== 1'b0 || fifo_level !== 3'd0)
      begin n_fail++; $display("FAIL drain_end got regwr %0b level %0d want 0/0", RegWr, fifo_level); end
  endtask

  task automatic test_collision();
    a_wr = 1; a_reg = 20; a_data = 32'h1;
    iss_valid = 1; iss_reg = 7;
    tick();
    iss_valid = 0;
    b_valid = 1; b_reg = 7; b_data = 32'h77;
    tick();
    b_reg = 0; b_data = 32'h99;
    tick();
    b_valid = 0;
    n_checks++; if (fifo_level !== 3'd2) begin n_fail++; $display("FAIL coll_level got %0d want 2", fifo_level); end
    a_wr = 0; iss_valid = 1; iss_reg = 7;
    tick();
    iss_valid = 0;
    n_checks++; if ({RegWr, WriteReg, WriteData} !== {1'b1, 5'd7, 32'h77})
      begin n_fail++; $display("FAIL coll_pop got %0b/%0d/%h want 1/7/77", RegWr, WriteReg, WriteData); end
    n_checks++; if (busy[7] !== 1'b1 || fifo_level !== 3'd1)
      begin n_fail++; $display("FAIL coll_setwins got busy7 %0b level %0d want 1/1", busy[7], fifo_level); end
    tick();
    n_checks++; if (RegWr !== 1'b0 || fifo_level !== 3'd0 || busy[7] !== 1'b1)
      begin n_fail++; $display("FAIL coll_r0 got regwr %0b level %0d busy7 %0b want 0/0/1", RegWr, fifo_level, busy[7]); end
    n_checks++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL coll_busy0 got %0b want 0", busy[0]); end
  endtask

  // Reference model: FIFO as a queue of {reg,data}, scoreboard as a plain bit vector
  task automatic test_random();
    logic [36:0] q[$];
    logic [36:0] e;
    logic        m_wr;
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    logic [31:0] m_busy;
    logic        hold_b;
    logic        ready_exp;
    logic        bypassed;
    Reset_n = 0;
    idle_inputs();
    tick();
    Reset_n = 1;
    m_wr = 0; m_reg = 0; m_data = 0; m_busy = 0;
    hold_b = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      a_wr   = ($urandom_range(0, 99) < 30);
      a_reg  = 5'($urandom_range(0, 31));
      a_data = $urandom;
      a_link = ($urandom_range(0, 99) < 10);
      a_pc   = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFC : $urandom;
      if (!hold_b) begin
        b_valid = ($urandom_range(0, 99) < 60);
        b_reg   = 5'($urandom_range(0, 31));
        b_data  = $urandom;
      end
      iss_valid = ($urandom_range(0, 99) < 40);
      iss_reg   = 5'($urandom_range(0, 31));
      #1;
      ready_exp = (q.size() != DEPTH);
      n_checks++; if (b_ready !== ready_exp)
        begin n_fail++; $display("FAIL rnd_bready cyc %0d got %0b want %0b", cyc, b_ready, ready_exp); end
      hold_b = b_valid && !ready_exp;

      bypassed = 0;
      m_wr = 0;
      if (a_wr && a_reg != 0) begin
        m_wr = 1; m_reg = a_reg; m_data = a_data;
      end else if (a_link) begin
        m_wr = 1; m_reg = 31; m_data = a_pc + 32'd4;
      end else if (q.size() > 0) begin
        e = q.pop_front();
        m_reg = e[36:32]; m_data = e[31:0]; m_wr = (m_reg != 0);
        m_busy[m_reg] = 0;
      end
`ifdef WB_BYPASS_EN
      else if (b_valid) begin
        bypassed = 1;
        m_reg = b_reg; m_data = b_data; m_wr = (b_reg != 0);
        m_busy[b_reg] = 0;
      end
`endif
      if (b_valid && ready_exp && !bypassed) q.push_back({b_reg, b_data});
      if (iss_valid && iss_reg != 0) m_busy[iss_reg] = 1;
      m_busy[0] = 0;

      tick();
      n_checks++; if (RegWr !== m_wr)
        begin n_fail++; $display("FAIL rnd_regwr cyc %0d got %0b want %0b", cyc, RegWr, m_wr); end
      n_checks++; if (WriteReg !== m_reg || WriteData !== m_data)
        begin n_fail++; $display("FAIL rnd_wdata cyc %0d got %0d/%h want %0d/%h", cyc, WriteReg, WriteData, m_reg, m_data); end
      n_checks++; if (busy !== m_busy)
        begin n_fail++; $display("FAIL rnd_busy cyc %0d got %h want %h", cyc, busy, m_busy); end
      n_checks++; if (fifo_level !== 3'(q.size()))
        begin n_fail++; $display("FAIL rnd_level cyc %0d got %0d want %0d", cyc, fifo_level, q.size()); end
    end
    idle_inputs();
  endtask

  initial begin
    Reset_n = 0;
    idle_inputs();
    test_reset();
    test_reset_mid();
    test_port_a();
    test_link();
    test_port_b_latency();
    test_fill_drain();
    test_collision();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
